// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one sequential shift-add multiplier among N requesters.
// Requests are granted round-robin. The operands of the winner are driven to the
// multiplier, a single init pulse is issued, and the arbiter waits for done.
// The product (or a timeout error) is returned to the winner with a one-cycle
// res_valid pulse. Every output is a register.
module mult_arbiter #(
  parameter int N       = 4,
  parameter int W       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   md_in,
  input  logic [N*W-1:0]   mr_in,
  output logic [N-1:0]     ack,
  output logic [N-1:0]     res_valid,
  output logic [2*W-1:0]   res,
  output logic             err,
  output logic             busy,
  output logic             m_init,
  output logic [W-1:0]     m_MD,
  output logic [W-1:0]     m_MR,
  input  logic [2*W-1:0]   m_pp,
  input  logic             m_done
);

  // Pointer and owner widths. With N=1 both collapse to one bit that is always 0.
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  // One extra bit holds ptr+offset (at most 2N-2) before it wraps.
  localparam int SW = PW + 1;
  // The WAIT counter only has to count up to TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(N - 1);
  localparam logic [SW-1:0] N_WIDE   = SW'(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GUARD,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_reg;
  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] owner_reg;
  logic [CW-1:0] cnt_reg;

  logic [W-1:0]  md_slice [N];
  logic [W-1:0]  mr_slice [N];
  logic [PW-1:0] cand_idx [N];
  logic [PW-1:0] win_idx;
  logic          win_found;
  logic [PW-1:0] owner_inc;

  // Unpack operands and build the scan order ptr, ptr+1, ... (mod N).
  // cand_idx[gi] is the requester examined at scan position gi.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [SW-1:0] sum;

    assign md_slice[gi] = md_in[gi*W +: W];
    assign mr_slice[gi] = mr_in[gi*W +: W];

    assign sum          = {1'b0, ptr_reg} + SW'(gi);
    assign cand_idx[gi] = (sum >= N_WIDE) ? PW'(sum - N_WIDE) : PW'(sum);
  end

  // Winner select: the first active request in the rotated scan order.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!win_found && req[cand_idx[k]]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

  // Requester after the owner: next round starts its scan there.
  assign owner_inc = (owner_reg == PTR_LAST) ? '0 : owner_reg + PW'(1);

  // Arbitration FSM. ack, m_init and res_valid default to 0 so that they are
  // single-cycle pulses. res and err hold their value until the next RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      cnt_reg   <= '0;
      ack       <= '0;
      res_valid <= '0;
      res       <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      m_init    <= 1'b0;
      m_MD      <= '0;
      m_MR      <= '0;
    end else begin
      ack       <= '0;
      res_valid <= '0;
      m_init    <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (win_found) begin
            owner_reg    <= win_idx;
            m_MD         <= md_slice[win_idx];
            m_MR         <= mr_slice[win_idx];
            m_init       <= 1'b1;
            ack[win_idx] <= 1'b1;
            busy         <= 1'b1;
            state_reg    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          state_reg <= S_GUARD;
        end

        // done may still be high from the previous multiplication here, so it
        // is deliberately not looked at in this state.
        S_GUARD: begin
          cnt_reg   <= '0;
          state_reg <= S_WAIT;
        end

        S_WAIT: begin
          if (m_done) begin
            res                  <= m_pp;
            err                  <= 1'b0;
            res_valid[owner_reg] <= 1'b1;
            state_reg            <= S_RESP;
          end else if (cnt_reg == CNT_LAST) begin
            res                  <= '0;
            err                  <= 1'b1;
            res_valid[owner_reg] <= 1'b1;
            state_reg            <= S_RESP;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        S_RESP: begin
          ptr_reg   <= owner_inc;
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one sequential 4x4 shift-add multiplier among N requesters.
- Each requester presents MD/MR operands. The block grants round-robin, pulses the multiplier `init`, waits for `done`, and returns the 2W-bit product to the owner.
- Sits between the requesting datapath units and the single multiplier instance.
- Includes a timeout so a hung multiplier cannot deadlock the requesters.

Parameters:
- N, 4, number of requesters.
- W, 4, operand width; product width is 2W.
- TIMEOUT, 64, maximum cycles spent in WAIT before aborting with error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  per-requester request level.
- md_in  in  N*W  packed multiplicands; slice i = [i*W +: W].
- mr_in  in  N*W  packed multipliers; slice i = [i*W +: W].
- ack  out  N  one-hot, one-cycle pulse: operands of requester i captured.
- res_valid  out  N  one-hot, one-cycle pulse: result for requester i on `res`/`err`.
- res  out  2W  product; valid only while res_valid is nonzero.
- err  out  1  timeout flag; qualified by res_valid.
- busy  out  1  high in every state except IDLE.
- m_init  out  1  to multiplier `init`.
- m_MD  out  W  to multiplier MD.
- m_MR  out  W  to multiplier MR.
- m_pp  in  2W  from multiplier pp.
- m_done  in  1  from multiplier done.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, ptr=0, owner=0, ack=0, res_valid=0, res=0, err=0, busy=0, m_init=0, m_MD=0, m_MR=0, timeout counter=0.
- FSM states: IDLE, ISSUE, GUARD, WAIT, RESP.
- IDLE:
  - If req is nonzero, select the winner: the first set bit scanning ptr, ptr+1, … mod N.
  - Latch owner, m_MD=md slice, m_MR=mr slice.
  - Next state ISSUE.
  - If req is zero, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - m_init=1, ack[owner]=1, busy=1.
  - Next state GUARD.
- GUARD (exactly 1 cycle):
  - m_init=0.
  - m_done is ignored, so a stale done left high from the previous operation is never taken.
  - Clear counter; next state WAIT.
- WAIT:
  - If m_done=1, latch res=m_pp, err=0; next state RESP.
  - Else if counter==TIMEOUT-1, set res=0, err=1; next state RESP.
  - Else increment counter.
- RESP (exactly 1 cycle):
  - res_valid[owner]=1.
  - ptr = (owner+1) mod N.
  - Next state IDLE.
  - res and err hold until the next RESP.
- m_MD and m_MR stay stable from ISSUE through RESP; they change only in IDLE on a grant.
- Latency:
  - req sampled in IDLE at cycle t → ack and m_init at t+1, GUARD at t+2, WAIT from t+3.
  - m_done sampled in WAIT at cycle d → res_valid at d+1.
  - Minimum turnaround from one grant to the next is 5 cycles.
- Requester rules:
  - Hold req and operands stable until ack.
  - Drop req in the cycle after ack, or it counts as a new request.
  - req changes during ISSUE..RESP have no effect on the current operation.
- Simultaneous requests: only one grant per pass through IDLE; pointer rotation guarantees every active requester is served within N operations.
- Reset in any state (including mid-WAIT):
  - Immediate return to reset values next cycle.
  - The in-flight result is discarded; no res_valid is issued for it.
  - The multiplier itself is not reset; its next m_init restarts it.
- N=1: the pointer is constant 0 and the FSM is unchanged.

Test Plan:
1. Single request: after reset, req=0001, md[0]=3, mr[0]=5, multiplier completes → ack[0] one cycle after req is sampled, m_init high exactly 1 cycle, res_valid=0001 with res=15, err=0, busy low the cycle after RESP.
2. All four request together with ptr=0: (MD,MR)=(2,3),(4,5),(7,7),(15,15) → ack/res_valid order 0,1,2,3 with res=6, 20, 49, 225; exactly one m_init per operation.
3. Round-robin fairness: req[0] and req[2] held high continuously (re-raised after each ack), operands 1*1 and 2*2 → grants alternate 0,2,0,2 over 4 operations; requester 0 is never granted twice in a row.
4. Timeout: multiplier stub with m_done tied 0, TIMEOUT=64 → res_valid[owner] exactly 64 cycles after WAIT entry, err=1, res=0; a subsequent request to a working multiplier succeeds with err=0.
5. Stale done: stub holds m_done=1 through ISSUE/GUARD, drops it, then reasserts after 8 cycles with m_pp=42 → res=42 taken at the reassertion; nothing captured during GUARD.
6. Reset mid-WAIT: rst=1 for 1 cycle during WAIT → next cycle all outputs 0, state IDLE, no res_valid for the aborted op; new req=0100 is granted with ptr=0 scan and returns the correct product.
